// File: rtl/wb_slave_burst_collector.sv
// Wishbone pipelined slave that gathers single/incrementing-burst cycles into circular message
// slots and presents complete messages to the packetiser over a valid/ready handshake.
module wb_slave_burst_collector #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADR_WIDTH    = 32,
  parameter int unsigned SEL_WIDTH    = 4,
  parameter int unsigned TGA_WIDTH    = 2,
  parameter int unsigned MAX_BEATS    = 8,
  parameter int unsigned N_BITS_BEATS = 4,
  parameter int unsigned N_SLOTS      = 4,
  parameter int unsigned N_BITS_SLOT  = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            CYC_I,
  input  logic                            STB_I,
  input  logic                            WE_I,
  input  logic [2:0]                      CTI_I,
  input  logic [ADR_WIDTH-1:0]            ADR_I,
  input  logic [DATA_WIDTH-1:0]           DAT_I,
  input  logic [SEL_WIDTH-1:0]            SEL_I,
  input  logic [TGA_WIDTH-1:0]            TGA_I,
  output logic                            ACK_O,
  output logic                            ERR_O,
  output logic                            RTY_O,
  output logic                            STALL_O,
  input  logic                            read_done_i,
  output logic                            msg_valid_o,
  input  logic                            msg_ready_i,
  output logic [MAX_BEATS*DATA_WIDTH-1:0] msg_data_o,
  output logic [N_BITS_BEATS-1:0]         msg_beats_o,
  output logic [ADR_WIDTH-1:0]            msg_adr_o,
  output logic [TGA_WIDTH-1:0]            msg_tga_o,
  output logic                            msg_we_o,
  output logic [N_BITS_SLOT-1:0]          msg_slot_o
);

  localparam logic [1:0] StIdle      = 2'd0;
  localparam logic [1:0] StCollect   = 2'd1;
  localparam logic [1:0] StWaitReply = 2'd2;
  localparam logic [1:0] StFlush     = 2'd3;

  localparam logic [2:0] CtiClassic = 3'b000;
  localparam logic [2:0] CtiEnd     = 3'b111;

  localparam logic [N_BITS_BEATS-1:0] MaxBeatsW = N_BITS_BEATS'(MAX_BEATS);
  localparam logic [N_BITS_SLOT:0]    SlotsFull = (N_BITS_SLOT + 1)'(N_SLOTS);

  logic [1:0]               state_q, state_d;
  logic [N_BITS_BEATS-1:0]  beats_q, beats_d;
  logic [N_BITS_SLOT-1:0]   wr_ptr_q, rd_ptr_q;
  logic [N_BITS_SLOT:0]     count_q;
  logic                     ack_q, ack_d;
  logic                     err_q, err_d;

  logic [MAX_BEATS*DATA_WIDTH-1:0] slot_data_q  [N_SLOTS];
  logic [N_BITS_BEATS-1:0]         slot_beats_q [N_SLOTS];
  logic [ADR_WIDTH-1:0]            slot_adr_q   [N_SLOTS];
  logic [TGA_WIDTH-1:0]            slot_tga_q   [N_SLOTS];
  logic                            slot_we_q    [N_SLOTS];

  logic                    full;
  logic                    resume;
  logic                    idle_like;
  logic                    stall;
  logic                    accept;
  logic                    commit;
  logic [N_BITS_BEATS-1:0] commit_beats;
  logic                    store_en;
  logic [N_BITS_BEATS-1:0] store_idx;
  logic                    first_beat;
  logic                    pop;

  // Byte selects are not carried in the message format.
  logic unused_sel;
  assign unused_sel = ^SEL_I;

  assign full      = (count_q == SlotsFull);
  assign pop       = (count_q != '0) && msg_ready_i;
  // The cycle that brings read_done_i behaves like IDLE so a queued beat is not held off.
  assign resume    = (state_q == StWaitReply) && read_done_i;
  assign idle_like = (state_q == StIdle) || resume;

  always_comb begin
    state_d      = state_q;
    beats_d      = beats_q;
    commit       = 1'b0;
    commit_beats = '0;
    store_en     = 1'b0;
    store_idx    = '0;
    first_beat   = 1'b0;
    ack_d        = 1'b0;
    err_d        = 1'b0;
    stall        = 1'b0;

    if ((state_q == StWaitReply) && !read_done_i) begin
      stall = 1'b1;
    end else if (idle_like) begin
      stall = full;
    end
    accept = CYC_I && STB_I && !stall;

    if (idle_like) begin
      state_d = StIdle;
      if (accept) begin
        store_en   = 1'b1;
        store_idx  = '0;
        first_beat = 1'b1;
        beats_d    = N_BITS_BEATS'(1);
        if (!WE_I) begin
          commit       = 1'b1;
          commit_beats = N_BITS_BEATS'(1);
          state_d      = StWaitReply;
        end else if ((CTI_I == CtiClassic) || (CTI_I == CtiEnd)) begin
          commit       = 1'b1;
          commit_beats = N_BITS_BEATS'(1);
          ack_d        = 1'b1;
        end else begin
          ack_d   = 1'b1;
          state_d = StCollect;
        end
      end
    end else begin
      case (state_q)
        StCollect: begin
          if (!CYC_I) begin
            // Master abandoned the burst; the half-built slot is simply not committed.
            state_d = StIdle;
          end else if (accept) begin
            if (beats_q == MaxBeatsW) begin
              err_d   = 1'b1;
              state_d = StFlush;
            end else begin
              store_en  = 1'b1;
              store_idx = beats_q;
              ack_d     = 1'b1;
              beats_d   = beats_q + 1'b1;
              if (CTI_I == CtiEnd) begin
                commit       = 1'b1;
                commit_beats = beats_q + 1'b1;
                state_d      = StIdle;
              end
            end
          end
        end
        StFlush: begin
          err_d = accept;
          if (!CYC_I) begin
            state_d = StIdle;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      beats_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      beats_q <= beats_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      if (commit) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({commit, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Slot payload needs no reset; a slot is only visible once committed.
  always_ff @(posedge clk) begin
    if (store_en) begin
      slot_data_q[wr_ptr_q][int'(store_idx)*DATA_WIDTH +: DATA_WIDTH] <= DAT_I;
    end
    if (first_beat) begin
      slot_adr_q[wr_ptr_q] <= ADR_I;
      slot_tga_q[wr_ptr_q] <= TGA_I;
      slot_we_q[wr_ptr_q]  <= WE_I;
    end
    if (commit) begin
      slot_beats_q[wr_ptr_q] <= commit_beats;
    end
  end

  assign ACK_O       = ack_q;
  assign ERR_O       = err_q;
  assign RTY_O       = 1'b0;
  assign STALL_O     = stall;
  assign msg_valid_o = (count_q != '0);
  assign msg_data_o  = slot_data_q[rd_ptr_q];
  assign msg_beats_o = slot_beats_q[rd_ptr_q];
  assign msg_adr_o   = slot_adr_q[rd_ptr_q];
  assign msg_tga_o   = slot_tga_q[rd_ptr_q];
  assign msg_we_o    = slot_we_q[rd_ptr_q];
  assign msg_slot_o  = rd_ptr_q;

endmodule

// File: tb/tb_wb_slave_burst_collector.sv
// Directed bench for wb_slave_burst_collector: a vector table for the basic flows plus
// hand-written sequences for full queue, overflow, abort and reset mid-burst.
module tb_wb_slave_burst_collector;

  logic         clk = 1'b0;
  logic         rst;
  logic         CYC_I, STB_I, WE_I;
  logic [2:0]   CTI_I;
  logic [31:0]  ADR_I, DAT_I;
  logic [3:0]   SEL_I;
  logic [1:0]   TGA_I;
  logic         ACK_O, ERR_O, RTY_O, STALL_O;
  logic         read_done_i;
  logic         msg_valid_o, msg_ready_i;
  logic [255:0] msg_data_o;
  logic [3:0]   msg_beats_o;
  logic [31:0]  msg_adr_o;
  logic [1:0]   msg_tga_o;
  logic         msg_we_o;
  logic [1:0]   msg_slot_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  wb_slave_burst_collector dut (
    .clk         (clk),
    .rst         (rst),
    .CYC_I       (CYC_I),
    .STB_I       (STB_I),
    .WE_I        (WE_I),
    .CTI_I       (CTI_I),
    .ADR_I       (ADR_I),
    .DAT_I       (DAT_I),
    .SEL_I       (SEL_I),
    .TGA_I       (TGA_I),
    .ACK_O       (ACK_O),
    .ERR_O       (ERR_O),
    .RTY_O       (RTY_O),
    .STALL_O     (STALL_O),
    .read_done_i (read_done_i),
    .msg_valid_o (msg_valid_o),
    .msg_ready_i (msg_ready_i),
    .msg_data_o  (msg_data_o),
    .msg_beats_o (msg_beats_o),
    .msg_adr_o   (msg_adr_o),
    .msg_tga_o   (msg_tga_o),
    .msg_we_o    (msg_we_o),
    .msg_slot_o  (msg_slot_o)
  );

  typedef struct {
    logic         cyc, stb, we;
    logic [2:0]   cti;
    logic [31:0]  adr, dat;
    logic         rdy, rdone;
    logic         ack, err, stall, valid, chk;
    logic [3:0]   beats;
    logic [31:0]  madr;
    logic         mwe;
    logic [1:0]   slot;
    logic [127:0] lanes;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic cyc, input logic we, input logic [2:0] cti,
                       input logic [31:0] adr, input logic [31:0] dat);
    CYC_I = cyc;
    STB_I = cyc;
    WE_I  = we;
    CTI_I = cti;
    ADR_I = adr;
    DAT_I = dat;
  endtask

  task automatic drive_idle();
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
  endtask

  task automatic chk_msg(input string nm, input logic [1:0] slot, input logic [3:0] beats,
                         input logic [31:0] adr, input logic [31:0] lane0);
    chk({nm, " valid"}, msg_valid_o, 1'b1);
    chk({nm, " slot"}, msg_slot_o, slot);
    chk({nm, " beats"}, msg_beats_o, beats);
    chk({nm, " adr"}, msg_adr_o, adr);
    chk({nm, " lane0"}, msg_data_o[31:0], lane0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    // cyc stb we cti adr dat rdy rdone | ack err stall valid chk beats madr mwe slot lanes
    vecs[0]  = '{1, 1, 1, 3'b000, 32'h100, 32'hCAFE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{0, 0, 0, 3'b000, 0, 0, 0, 0, 1, 0, 0, 1, 1, 1, 32'h100, 1, 0, 128'hCAFE};
    vecs[2]  = '{0, 0, 0, 3'b000, 0, 0, 1, 0, 0, 0, 0, 1, 1, 1, 32'h100, 1, 0, 128'hCAFE};
    vecs[3]  = '{0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[4]  = '{1, 1, 1, 3'b010, 32'h200, 32'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[5]  = '{1, 1, 1, 3'b010, 32'h204, 32'd2, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[6]  = '{1, 1, 1, 3'b010, 32'h208, 32'd3, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[7]  = '{1, 1, 1, 3'b111, 32'h20C, 32'd4, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[8]  = '{0, 0, 0, 3'b000, 0, 0, 0, 0, 1, 0, 0, 1, 1, 4, 32'h200, 1, 1,
                 {32'd4, 32'd3, 32'd2, 32'd1}};
    vecs[9]  = '{0, 0, 0, 3'b000, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    vecs[10] = '{0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[11] = '{1, 1, 0, 3'b000, 32'h40, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[12] = '{0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 32'h40, 0, 2, 128'h0};
    vecs[13] = '{0, 0, 0, 3'b000, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    vecs[14] = '{0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    rst = 1'b1;
    SEL_I = 4'hF;
    TGA_I = 2'd1;
    msg_ready_i = 1'b0;
    read_done_i = 1'b0;
    drive_idle();
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("reset ack", ACK_O, 1'b0);
    chk("reset err", ERR_O, 1'b0);
    chk("reset stall", STALL_O, 1'b0);
    chk("reset valid", msg_valid_o, 1'b0);
    chk("reset rty", RTY_O, 1'b0);
    tick();

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].cyc, vecs[i].we, vecs[i].cti, vecs[i].adr, vecs[i].dat);
      STB_I = vecs[i].stb;
      msg_ready_i = vecs[i].rdy;
      read_done_i = vecs[i].rdone;
      #1;
      chk($sformatf("v%0d ack", i), ACK_O, vecs[i].ack);
      chk($sformatf("v%0d err", i), ERR_O, vecs[i].err);
      chk($sformatf("v%0d stall", i), STALL_O, vecs[i].stall);
      chk($sformatf("v%0d valid", i), msg_valid_o, vecs[i].valid);
      if (vecs[i].chk) begin
        chk($sformatf("v%0d beats", i), msg_beats_o, vecs[i].beats);
        chk($sformatf("v%0d adr", i), msg_adr_o, vecs[i].madr);
        chk($sformatf("v%0d we", i), msg_we_o, vecs[i].mwe);
        chk($sformatf("v%0d slot", i), msg_slot_o, vecs[i].slot);
        chk($sformatf("v%0d tga", i), msg_tga_o, 2'd1);
        for (int k = 0; k < 4; k++) begin
          if (k < int'(vecs[i].beats)) begin
            chk($sformatf("v%0d lane%0d", i, k), msg_data_o[k*32 +: 32],
                vecs[i].lanes[k*32 +: 32]);
          end
        end
      end
      tick();
    end
    msg_ready_i = 1'b0;
    read_done_i = 1'b0;

    // Full queue: four single writes fill slots 0..3, a fifth beat waits for one pop.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 3'b000, 32'h300 + i, i + 1);
      tick();
    end
    drive(1'b1, 1'b1, 3'b000, 32'h3F0, 32'd5);
    #1;
    chk("full stall", STALL_O, 1'b1);
    chk_msg("full head", 2'd0, 4'd1, 32'h300, 32'd1);
    tick();
    #1;
    chk("full no ack", ACK_O, 1'b0);
    chk("full still stall", STALL_O, 1'b1);
    msg_ready_i = 1'b1;
    #1;
    chk("full stall during pop", STALL_O, 1'b1);
    tick();
    msg_ready_i = 1'b0;
    #1;
    chk("after pop stall", STALL_O, 1'b0);
    chk("after pop slot", msg_slot_o, 2'd1);
    tick();
    drive_idle();
    #1;
    chk("fifth ack", ACK_O, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      chk_msg($sformatf("drain%0d", k), 2'(k % 4), 4'd1, (k == 4) ? 32'h3F0 : 32'h300 + k,
              k + 1);
      msg_ready_i = 1'b1;
      tick();
      msg_ready_i = 1'b0;
    end
    #1;
    chk("drained valid", msg_valid_o, 1'b0);

    // Overflow: 9 beats then one more inside the flush, all held in one cycle.
    for (int j = 0; j < 10; j++) begin
      drive(1'b1, 1'b1, (j == 8) ? 3'b111 : 3'b010, 32'h500 + 4 * j, j + 1);
      tick();
      #1;
      chk($sformatf("ovf beat%0d ack", j), ACK_O, j < 8);
      chk($sformatf("ovf beat%0d err", j), ERR_O, j >= 8);
    end
    drive_idle();
    tick();
    #1;
    chk("ovf err clear", ERR_O, 1'b0);
    chk("ovf no msg", msg_valid_o, 1'b0);
    chk("ovf stall", STALL_O, 1'b0);
    drive(1'b1, 1'b1, 3'b000, 32'h600, 32'h66);
    tick();
    drive_idle();
    #1;
    chk("post ovf ack", ACK_O, 1'b1);
    chk_msg("post ovf", 2'd1, 4'd1, 32'h600, 32'h66);
    msg_ready_i = 1'b1;
    tick();
    msg_ready_i = 1'b0;

    // Abort after two of four beats: nothing committed, slot index reused.
    drive(1'b1, 1'b1, 3'b010, 32'h700, 32'h71);
    tick();
    drive(1'b1, 1'b1, 3'b010, 32'h704, 32'h72);
    #1;
    chk("abort beat1 ack", ACK_O, 1'b1);
    tick();
    drive_idle();
    #1;
    chk("abort beat2 ack", ACK_O, 1'b1);
    tick();
    #1;
    chk("abort no msg", msg_valid_o, 1'b0);
    chk("abort no ack", ACK_O, 1'b0);
    drive(1'b1, 1'b1, 3'b000, 32'h800, 32'h88);
    tick();
    drive_idle();
    #1;
    chk_msg("post abort", 2'd2, 4'd1, 32'h800, 32'h88);
    msg_ready_i = 1'b1;
    tick();
    msg_ready_i = 1'b0;

    // Reset in the cycle a burst beat is accepted: its ACK never appears.
    drive(1'b1, 1'b1, 3'b010, 32'h900, 32'h91);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive_idle();
    #1;
    chk("rst ack suppressed", ACK_O, 1'b0);
    chk("rst valid", msg_valid_o, 1'b0);
    chk("rst stall", STALL_O, 1'b0);
    drive(1'b1, 1'b1, 3'b000, 32'h980, 32'h99);
    tick();
    drive_idle();
    #1;
    chk_msg("post rst", 2'd0, 4'd1, 32'h980, 32'h99);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
